// File: rtl/ex_arith_unit.sv
// Arithmetic core of the 64-bit pipeline: execute-stage ALU, fetch PC+step adder,
// decode branch-target adder, and a stall-aware EX/MEM result register.
module ex_arith_unit #(
  parameter int XLEN    = 64,
  parameter int PC_STEP = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [2:0]      ALU_Sel,
  output logic [XLEN-1:0] ALU_Out,
  output logic            zero,
  input  logic            en,
  output logic [XLEN-1:0] alu_q,
  output logic            zero_q,
  input  logic [XLEN-1:0] fetch_pc,
  output logic [XLEN-1:0] pc_plus,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] branch_target
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_SLT = 3'b111
  } alu_op_e;

  logic [5:0]      shamt;
  logic            slt_bit;
  logic [XLEN-1:0] imm_sh;
  logic [XLEN-1:0] alu_d;
  logic            zero_d;

  // Only the low six bits of B steer the shifter; the rest are don't-care.
  assign shamt   = B[5:0];
  assign slt_bit = ($signed(A) < $signed(B));

  always_comb begin
    ALU_Out = '0;
    case (alu_op_e'(ALU_Sel))
      OP_ADD:  ALU_Out = A + B;
      OP_SUB:  ALU_Out = A - B;
      OP_AND:  ALU_Out = A & B;
      OP_OR:   ALU_Out = A | B;
      OP_XOR:  ALU_Out = A ^ B;
      OP_SLL:  ALU_Out = A << shamt;
      OP_SRL:  ALU_Out = A >> shamt;
      OP_SLT:  ALU_Out = {{(XLEN-1){1'b0}}, slt_bit};
      default: ALU_Out = '0;
    endcase
  end

  assign zero = (ALU_Out == '0);

  // Both adders wrap modulo 2^XLEN; the immediate's MSB is dropped by the shift.
  assign imm_sh        = {imm[XLEN-2:0], 1'b0};
  assign pc_plus       = fetch_pc + XLEN'(PC_STEP);
  assign branch_target = id_pc + imm_sh;

  // en is a plain capture enable: high loads on the rising edge, low holds (stall).
  always_comb begin
    alu_d  = alu_q;
    zero_d = zero_q;
    if (en) begin
      alu_d  = ALU_Out;
      zero_d = zero;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      alu_q  <= alu_d;
      zero_q <= zero_d;
    end
  end

endmodule

// File: tb/tb_ex_arith_unit.sv
// Directed-vector bench for ex_arith_unit: combinational ALU/adders and the
// stall-aware capture register, with an expected queue for registered results.
module tb_ex_arith_unit;

  localparam int XLEN = 64;

  logic            clk;
  logic            rst;
  logic [XLEN-1:0] A, B;
  logic [2:0]      ALU_Sel;
  logic [XLEN-1:0] ALU_Out;
  logic            zero;
  logic            en;
  logic [XLEN-1:0] alu_q;
  logic            zero_q;
  logic [XLEN-1:0] fetch_pc, pc_plus;
  logic [XLEN-1:0] id_pc, imm, branch_target;

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] exp_q[$];

  ex_arith_unit #(.XLEN(XLEN), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .ALU_Sel(ALU_Sel),
    .ALU_Out(ALU_Out), .zero(zero), .en(en), .alu_q(alu_q), .zero_q(zero_q),
    .fetch_pc(fetch_pc), .pc_plus(pc_plus), .id_pc(id_pc), .imm(imm),
    .branch_target(branch_target)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, need completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive ALU inputs away from the edge and check the combinational result.
  task automatic drive_alu(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [2:0] sel);
    @(negedge clk);
    A = a; B = b; ALU_Sel = sel;
    #1;
  endtask

  task automatic alu_vec(input string tag, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [2:0] sel, input logic [XLEN-1:0] exp);
    drive_alu(a, b, sel);
    check(tag, ALU_Out, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push expected register value, clock once, and pop/compare.
  task automatic capture(input string tag, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [2:0] sel, input logic [XLEN-1:0] exp);
    drive_alu(a, b, sel);
    en = 1'b1;
    exp_q.push_back(exp);
    step();
    check(tag, alu_q, exp_q.pop_front());
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; A = '0; B = '0; ALU_Sel = 3'b000;
    fetch_pc = '0; id_pc = '0; imm = '0;
    #12;
    check("rst_alu_q", alu_q, 64'h0);
    check("rst_zero_q", 64'(zero_q), 64'h0);
    @(negedge clk);
    rst = 1'b1;

    // 1. reset mid-cycle clears the register before the next edge
    capture("pre_rst_capture", 64'h55, 64'h0, 3'b000, 64'h55);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_alu_q", alu_q, 64'h0);
    check("async_rst_zero_q", 64'(zero_q), 64'h0);
    step();
    check("rst_held_over_edge", alu_q, 64'h0);
    drive_alu(64'd3, 64'd4, 3'b000);
    en = 1'b1;
    rst = 1'b1;
    step();
    check("first_capture_after_rst", alu_q, 64'd7);

    // 2. ALU sweep
    alu_vec("add", 64'h0F, 64'h03, 3'b000, 64'h12);
    alu_vec("sub", 64'h0F, 64'h03, 3'b001, 64'h0C);
    alu_vec("and", 64'h0F, 64'h03, 3'b010, 64'h03);
    alu_vec("or",  64'h0F, 64'h03, 3'b011, 64'h0F);
    alu_vec("xor", 64'h0F, 64'h03, 3'b100, 64'h0C);
    alu_vec("sll", 64'h0F, 64'h03, 3'b101, 64'h78);
    alu_vec("srl", 64'h0F, 64'h03, 3'b110, 64'h01);
    alu_vec("slt", 64'h0F, 64'h03, 3'b111, 64'h00);
    check("slt_zero_flag", 64'(zero), 64'h1);

    // 3. signed and boundary cases
    alu_vec("slt_neg", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'b111, 64'h1);
    check("slt_neg_zero", 64'(zero), 64'h0);
    alu_vec("slt_uns_big", 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b111, 64'h0);
    alu_vec("sub_eq", 64'd5, 64'd5, 3'b001, 64'h0);
    check("sub_eq_zero", 64'(zero), 64'h1);
    alu_vec("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'b000, 64'h0);
    check("add_wrap_zero", 64'(zero), 64'h1);
    alu_vec("sll_mask", 64'h0F, 64'h41, 3'b101, 64'h1E);
    alu_vec("srl_msb", 64'h8000_0000_0000_0000, 64'd63, 3'b110, 64'h1);
    alu_vec("sub_neg", 64'd3, 64'd5, 3'b001, 64'hFFFF_FFFF_FFFF_FFFE);
    capture("zero_q_capture", 64'd5, 64'd5, 3'b001, 64'h0);
    check("zero_q_set", 64'(zero_q), 64'h1);

    // 4. PC adders
    @(negedge clk);
    fetch_pc = 64'h10; #1;
    check("pc_plus", pc_plus, 64'h14);
    fetch_pc = 64'hFFFF_FFFF_FFFF_FFFC; #1;
    check("pc_plus_wrap", pc_plus, 64'h0);
    id_pc = 64'h20; imm = 64'hFFFF_FFFF_FFFF_FFFC; #1;
    check("branch_back", branch_target, 64'h18);
    id_pc = 64'h100; imm = 64'h8; #1;
    check("branch_fwd", branch_target, 64'h110);

    // 5. stall
    capture("stall_load", 64'h0F, 64'h03, 3'b000, 64'h12);
    check("stall_load_zero_q", 64'(zero_q), 64'h0);
    for (int i = 0; i < 3; i++) begin
      drive_alu(64'(i), 64'h0, 3'b000);
      en = 1'b0;
      step();
      check("stall_hold", alu_q, 64'h12);
      check("stall_hold_zero_q", 64'(zero_q), 64'h0);
    end
    capture("stall_release", 64'h21, 64'h21, 3'b000, 64'h42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
